spi_edge_tx: RTL and testbench

//  - SPI slave transmitter: the return path of the SPI link. It streams edge-detector

---
 rtl/spi_edge_tx_if.sv | 37 +++
 rtl/spi_edge_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_edge_tx.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_edge_tx_if.sv
// Signal bundle between the edge detector / SPI pads and the spi_edge_tx return-path transmitter.
// master = the side that produces pixels and drives the SPI pins; slave = spi_edge_tx itself.
interface spi_edge_tx_if;
    logic [1:0] edgeVal;
    logic       edgeValid;
    logic       inReady;
    logic       spiClk;
    logic       ncs;
    logic       sdo;
    logic       sdoEn;
    logic       overflow;
    logic [6:0] fifoCount;

    modport master (
        output edgeVal,
        output edgeValid,
        output spiClk,
        output ncs,
        input  inReady,
        input  sdo,
        input  sdoEn,
        input  overflow,
        input  fifoCount
    );

    modport slave (
        input  edgeVal,
        input  edgeValid,
        input  spiClk,
        input  ncs,
        output inReady,
        output sdo,
        output sdoEn,
        output overflow,
        output fifoCount
    );
endinterface

// File: rtl/spi_edge_tx.sv
// SPI mode-0 slave transmitter: packs 2-bit edge values four per byte into a FIFO and shifts them out on sdo.
// Optional macro SPI_EDGE_TX_STATUS_EN prefixes every transaction with a {overflow, fifoCount} status byte.
module spi_edge_tx #(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] FILL_BYTE  = 8'h00
) (
    input logic          mainClk,
    input logic          rst,
    spi_edge_tx_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers: bit 0 = spiClk, bit 1 = ncs.
    // Flops reset low, so an ncs fall can only be seen after ncs was sampled
    // high since reset; a transfer already running at reset is ignored.
    // ------------------------------------------------------------------
    logic [1:0] pin_raw;
    logic [1:0] pin_s2;
    logic [1:0] pin_s3;

    assign pin_raw = {bus.ncs, bus.spiClk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [2:0] sh_q;
            always_ff @(posedge mainClk) begin
                if (rst) begin
                    sh_q <= 3'b000;
                end else begin
                    sh_q <= {sh_q[1:0], pin_raw[gi]};
                end
            end
            assign pin_s2[gi] = sh_q[1];
            assign pin_s3[gi] = sh_q[2];
        end
    endgenerate

    logic spi_fall;
    logic ncs_fall;
    logic ncs_rise;

    assign spi_fall = !pin_s2[0] && pin_s3[0];
    assign ncs_fall = !pin_s2[1] && pin_s3[1];
    assign ncs_rise = pin_s2[1] && !pin_s3[1];

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [6:0]    count_q;
    logic [6:0]    count_d;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic [7:0]    head_byte;

    // ------------------------------------------------------------------
    // Packer
    // ------------------------------------------------------------------
    logic [7:0] pack_q;
    logic [7:0] pack_d;
    logic [1:0] pix_cnt_q;
    logic       push_q;
    logic       accept;
    logic       drop;

    // A completed byte waiting in push_q already owns a FIFO slot.
    assign fifo_empty = (count_q == 7'd0);
    assign fifo_full  = ((count_q + {6'd0, push_q}) >= 7'(FIFO_DEPTH));
    assign accept     = bus.edgeValid && !fifo_full;
    assign drop       = bus.edgeValid && fifo_full;
    assign head_byte  = fifo_empty ? FILL_BYTE : mem_q[rd_ptr_q];

    always_comb begin
        pack_d = pack_q;
        for (int k = 0; k < 4; k++) begin
            if (pix_cnt_q == 2'(k)) begin
                pack_d[7-2*k -: 2] = bus.edgeVal;
            end
        end
    end

    always_ff @(posedge mainClk) begin
        if (rst) begin
            pack_q    <= 8'h00;
            pix_cnt_q <= 2'd0;
            push_q    <= 1'b0;
        end else begin
            push_q <= accept && (pix_cnt_q == 2'd3);
            if (accept) begin
                pack_q    <= pack_d;
                pix_cnt_q <= pix_cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge mainClk) begin
        if (push_q) begin
            mem_q[wr_ptr_q] <= pack_q;
        end
    end

    assign count_d = count_q + {6'd0, push_q} - {6'd0, pop};

    always_ff @(posedge mainClk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 7'd0;
        end else begin
            count_q <= count_d;
            if (push_q) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [7:0] shreg_q;
    logic [7:0] shreg_d;
    logic [2:0] bit_cnt_q;
    logic [2:0] bit_cnt_d;
    logic       overflow_q;
    logic       overflow_d;
`ifdef SPI_EDGE_TX_STATUS_EN
    logic       status_q;
    logic       status_d;
`endif

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        overflow_d = overflow_q || drop;
        pop        = 1'b0;
`ifdef SPI_EDGE_TX_STATUS_EN
        status_d   = status_q;
`endif
        if (ncs_rise) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
`ifdef SPI_EDGE_TX_STATUS_EN
                    shreg_d  = {overflow_q, count_q};
                    status_d = 1'b1;
`else
                    shreg_d = head_byte;
                    pop     = !fifo_empty;
`endif
                    bit_cnt_d = 3'd0;
                    state_d   = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (spi_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            shreg_d   = head_byte;
                            pop       = !fifo_empty;
                            bit_cnt_d = 3'd0;
`ifdef SPI_EDGE_TX_STATUS_EN
                            // Status byte fully sent: the MCU has seen the flag.
                            if (status_q) begin
                                status_d   = 1'b0;
                                overflow_d = drop;
                            end
`endif
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge mainClk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            overflow_q <= 1'b0;
`ifdef SPI_EDGE_TX_STATUS_EN
            status_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            overflow_q <= overflow_d;
`ifdef SPI_EDGE_TX_STATUS_EN
            status_q   <= status_d;
`endif
        end
    end

    assign bus.inReady   = !fifo_full;
    assign bus.sdo       = (state_q == ST_SHIFT) && shreg_q[7];
    assign bus.sdoEn     = (state_q == ST_SHIFT);
    assign bus.overflow  = overflow_q;
    assign bus.fifoCount = count_q;
endmodule

// File: tb/tb_spi_edge_tx.sv
// Directed bench for spi_edge_tx: pixel packing, SPI readout, overflow, aborts and reset mid-transfer.
// Build with +define+SPI_EDGE_TX_STATUS_EN to exercise the status-byte variant.
module tb_spi_edge_tx;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    spi_edge_tx_if bus ();

    spi_edge_tx #(
        .FIFO_DEPTH(16),
        .FILL_BYTE (8'h00)
    ) dut (
        .mainClk(clk),
        .rst    (rst),
        .bus    (bus)
    );

`ifdef SPI_EDGE_TX_STATUS_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] got [0:15];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Byte k of the overflow test: pixel 4k+j carries (k+j) mod 4.
    function automatic logic [7:0] exp_byte(input int k);
        logic [1:0] a;
        a = 2'(k);
        return {a, a + 2'd1, a + 2'd2, a + 2'd3};
    endfunction

    task automatic push_pixel(input logic [1:0] v);
        bus.edgeVal   = v;
        bus.edgeValid = 1'b1;
        tick(1);
        bus.edgeValid = 1'b0;
    endtask

    // Full-byte SPI read; if hold_first, edgeValid is dropped right after the first byte's last fall is acted on.
    task automatic xfer(input int nbytes, input bit hold_first);
        logic [7:0] b;
        string      s;
        s       = "";
        bus.ncs = 1'b0;
        tick(4);
        check_eq("sdoen_on", 32'(bus.sdoEn), 32'd1);
        tick(2);
        for (int i = 0; i < nbytes; i++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) begin
                b          = {b[6:0], bus.sdo};
                bus.spiClk = 1'b1;
                tick(4);
                bus.spiClk = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    tick(1);
                    if (hold_first && i == 0 && j == 7 && c == 2) bus.edgeValid = 1'b0;
                end
            end
            got[i] = b;
            s      = {s, $sformatf(" %02h", b)};
        end
        bus.ncs = 1'b1;
        tick(4);
        check_eq("sdoen_off", 32'(bus.sdoEn), 32'd0);
        check_eq("sdo_idle", 32'(bus.sdo), 32'd0);
        $display("xfer bytes=%0d data:%s fifoCount=%0d overflow=%0d", nbytes, s, bus.fifoCount, bus.overflow);
    endtask

    task automatic xfer_bits(input int nbits);
        bus.ncs = 1'b0;
        tick(6);
        for (int j = 0; j < nbits; j++) begin
            bus.spiClk = 1'b1;
            tick(4);
            bus.spiClk = 1'b0;
            tick(4);
        end
        bus.ncs = 1'b1;
        tick(4);
        check_eq("abort_sdoen_off", 32'(bus.sdoEn), 32'd0);
        $display("xfer aborted after %0d bits fifoCount=%0d", nbits, bus.fifoCount);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got time limit, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] seq1 [8];
        int acc;
        int first_block;
        int en_seen;

        seq1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        rst           = 1'b1;
        bus.ncs       = 1'b1;
        bus.spiClk    = 1'b0;
        bus.edgeValid = 1'b0;
        bus.edgeVal   = 2'd0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_eq("rst_sdo", 32'(bus.sdo), 32'd0);
        check_eq("rst_sdoen", 32'(bus.sdoEn), 32'd0);
        check_eq("rst_inready", 32'(bus.inReady), 32'd1);
        check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
        check_eq("rst_count", 32'(bus.fifoCount), 32'd0);

        // Two bytes 0x1B, 0xE4
        for (int i = 0; i < 8; i++) push_pixel(seq1[i]);
        tick(2);
        check_eq("t1_count", 32'(bus.fifoCount), 32'd2);
        xfer(HDR + 2, 1'b0);
`ifdef SPI_EDGE_TX_STATUS_EN
        check_eq("t1_status", 32'(got[0]), 32'h02);
`endif
        check_eq("t1_byte0", 32'(got[HDR]), 32'h1B);
        check_eq("t1_byte1", 32'(got[HDR+1]), 32'hE4);
        check_eq("t1_count_after", 32'(bus.fifoCount), 32'd0);

        // Empty FIFO: fill bytes only
        xfer(HDR + 3, 1'b0);
        for (int i = 0; i < HDR + 3; i++) check_eq($sformatf("t2_fill%0d", i), 32'(got[i]), 32'h00);
        check_eq("t2_count", 32'(bus.fifoCount), 32'd0);

        // 68 back-to-back pixels into a 16-byte FIFO
        acc         = 0;
        first_block = -1;
        for (int i = 0; i < 68; i++) begin
            bus.edgeVal   = 2'(i + i / 4);
            bus.edgeValid = 1'b1;
            if (bus.inReady) acc++;
            else if (first_block < 0) first_block = i;
            tick(1);
        end
        bus.edgeValid = 1'b0;
        tick(2);
        check_eq("t3_accepted", 32'(acc), 32'd64);
        check_eq("t3_first_block", 32'(first_block), 32'd64);
        check_eq("t3_overflow", 32'(bus.overflow), 32'd1);
        check_eq("t3_count", 32'(bus.fifoCount), 32'd16);
        check_eq("t3_inready", 32'(bus.inReady), 32'd0);

`ifdef SPI_EDGE_TX_STATUS_EN
        // Keep dropping pixels until the status byte is fully sent so overflow survives its clear.
        bus.edgeValid = 1'b1;
        xfer(14, 1'b1);
        check_eq("t6a_status", 32'(got[0]), 32'h90);
        for (int i = 0; i < 13; i++) check_eq($sformatf("t6a_data%0d", i), 32'(got[i+1]), 32'(exp_byte(i)));
        check_eq("t6a_overflow_kept", 32'(bus.overflow), 32'd1);
`else
        xfer(13, 1'b0);
        for (int i = 0; i < 13; i++) check_eq($sformatf("t3_data%0d", i), 32'(got[i]), 32'(exp_byte(i)));
        check_eq("t3_overflow_sticky", 32'(bus.overflow), 32'd1);
`endif
        check_eq("t3_count_left", 32'(bus.fifoCount), 32'd2);

        // Abort after 3 bits, then read on
        xfer_bits(3);
`ifdef SPI_EDGE_TX_STATUS_EN
        check_eq("t4_count", 32'(bus.fifoCount), 32'd2);
        xfer(3, 1'b0);
        check_eq("t6_status", 32'(got[0]), 32'h82);
        check_eq("t6_data0", 32'(got[1]), 32'(exp_byte(14)));
        check_eq("t6_data1", 32'(got[2]), 32'(exp_byte(15)));
        check_eq("t6_overflow_clr", 32'(bus.overflow), 32'd0);
`else
        check_eq("t4_count", 32'(bus.fifoCount), 32'd1);
        xfer(1, 1'b0);
        check_eq("t4_next_byte", 32'(got[0]), 32'(exp_byte(15)));
        check_eq("t4_overflow", 32'(bus.overflow), 32'd1);
`endif
        check_eq("t4_count_after", 32'(bus.fifoCount), 32'd0);

        // Reset mid-byte with ncs held low
        for (int i = 0; i < 8; i++) push_pixel(seq1[i % 4]);
        tick(2);
        bus.ncs = 1'b0;
        tick(6);
        for (int j = 0; j < 3; j++) begin
            bus.spiClk = 1'b1;
            tick(4);
            bus.spiClk = 1'b0;
            tick(4);
        end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_eq("t5_sdo", 32'(bus.sdo), 32'd0);
        check_eq("t5_sdoen", 32'(bus.sdoEn), 32'd0);
        check_eq("t5_inready", 32'(bus.inReady), 32'd1);
        check_eq("t5_overflow", 32'(bus.overflow), 32'd0);
        check_eq("t5_count", 32'(bus.fifoCount), 32'd0);
        en_seen = 0;
        for (int j = 0; j < 8; j++) begin
            bus.spiClk = 1'b1;
            for (int c = 0; c < 4; c++) begin
                tick(1);
                if (bus.sdoEn) en_seen++;
            end
            bus.spiClk = 1'b0;
            for (int c = 0; c < 4; c++) begin
                tick(1);
                if (bus.sdoEn) en_seen++;
            end
        end
        check_eq("t5_no_shift", 32'(en_seen), 32'd0);
        $display("xfer ignored: 8 spiClk cycles with ncs low across reset");
        push_pixel(2'd2);
        push_pixel(2'd1);
        push_pixel(2'd3);
        push_pixel(2'd0);
        tick(2);
        check_eq("t5_count_push", 32'(bus.fifoCount), 32'd1);
        bus.ncs = 1'b1;
        tick(4);
        xfer(HDR + 1, 1'b0);
`ifdef SPI_EDGE_TX_STATUS_EN
        check_eq("t5_status", 32'(got[0]), 32'h01);
`endif
        check_eq("t5_byte", 32'(got[HDR]), 32'h9C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
